// File: rtl/pattern_scan_sched_if.sv
// Bundle of requester, detector and result signals for pattern_scan_sched.
// The slave modport is the scheduler's side; master is the surrounding environment.
interface pattern_scan_sched_if #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
);
  logic          req0;
  logic          req1;
  logic [W-1:0]  data0;
  logic [W-1:0]  data1;
  logic          ack0;
  logic          ack1;
  logic          det_in;
  logic          det_reset_n;
  logic          det_z;
  logic          busy;
  logic          res_valid;
  logic          res_id;
  logic [CW-1:0] res_count;
  logic          res_hit;

  modport slave (
    input  req0, req1, data0, data1, det_z,
    output ack0, ack1, det_in, det_reset_n, busy,
    output res_valid, res_id, res_count, res_hit
  );

  modport master (
    output req0, req1, data0, data1, det_z,
    input  ack0, ack1, det_in, det_reset_n, busy,
    input  res_valid, res_id, res_count, res_hit
  );
endinterface

// File: rtl/pattern_scan_sched.sv
// Round-robin scheduler feeding one bit-serial pattern detector from two word requesters,
// returning a per-word match count tagged with the served requester id.
module pattern_scan_sched #(
  parameter int W        = 8,
  parameter bit CLEAR_EN = 1'b1,
  parameter int CW       = $clog2(W + 1)
) (
  input logic                  clk,
  input logic                  reset,
  pattern_scan_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] res_count_q, res_count_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          res_id_q, res_id_d;
  logic          res_hit_q, res_hit_d;
  logic          grant1;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    last_d      = last_q;
    id_d        = id_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    res_count_d = res_count_q;
    res_id_d    = res_id_q;
    res_hit_d   = res_hit_q;
    // On a tie, requester 1 wins only if requester 0 was served last.
    grant1      = bus.req1 & (~bus.req0 | ~last_q);

    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          id_d    = grant1;
          last_d  = grant1;
          sr_d    = grant1 ? bus.data1 : bus.data0;
          cnt_d   = '0;
          idx_d   = '0;
          ack0_d  = ~grant1;
          ack1_d  = grant1;
          state_d = CLEAR_EN ? CLEAR : SHIFT;
        end
      end
      CLEAR: state_d = SHIFT;
      SHIFT: begin
        cnt_d = cnt_q + CW'(bus.det_z);
        sr_d  = sr_q >> 1;
        idx_d = idx_q + CW'(1);
        // The last det_z of the word arrives on the edge that leaves SHIFT,
        // so the result is captured from the already-incremented count.
        if (idx_q == CW'(W - 1)) begin
          state_d     = DONE;
          res_count_d = cnt_d;
          res_id_d    = id_q;
          res_hit_d   = (cnt_d != '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      res_count_q <= '0;
      res_id_q    <= 1'b0;
      res_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      id_q        <= id_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      res_count_q <= res_count_d;
      res_id_q    <= res_id_d;
      res_hit_q   <= res_hit_d;
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.res_valid   = (state_q == DONE);
  assign bus.det_in      = (state_q == SHIFT) & sr_q[0];
  assign bus.det_reset_n = ~reset & (state_q != CLEAR);
  assign bus.res_id      = res_id_q;
  assign bus.res_count   = res_count_q;
  assign bus.res_hit     = res_hit_q;

endmodule

// File: tb/tb_pattern_scan_sched.sv
// Directed bench: one scheduler with detector clear, one without, each driving a
// behavioural 0100 / 00010 detector that consumes a bit in every shifting cycle.
module tb_pattern_scan_sched;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  pattern_scan_sched_if #(.W(8)) b1 ();
  pattern_scan_sched_if #(.W(8)) b0 ();

  pattern_scan_sched #(.W(8), .CLEAR_EN(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  pattern_scan_sched #(.W(8), .CLEAR_EN(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));

  // Detector history, newest bit in the LSB; all-ones means "nothing seen yet".
  logic [4:0] h1, h0;

  function automatic logic det_hit(input logic [4:0] h);
    return (h[3:0] == 4'b0100) || (h == 5'b00010);
  endfunction

  always @(negedge clk) begin
    if (!b1.det_reset_n) begin
      h1 <= 5'h1f; b1.det_z <= 1'b0;
    end else if (b1.busy && !b1.res_valid) begin
      h1 <= {h1[3:0], b1.det_in}; b1.det_z <= det_hit({h1[3:0], b1.det_in});
    end else begin
      b1.det_z <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!b0.det_reset_n) begin
      h0 <= 5'h1f; b0.det_z <= 1'b0;
    end else if (b0.busy && !b0.res_valid) begin
      h0 <= {h0[3:0], b0.det_in}; b0.det_z <= det_hit({h0[3:0], b0.det_in});
    end else begin
      b0.det_z <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_req(input bit inst, input bit id, input logic r, input logic [7:0] d);
    if (inst) begin
      if (id) begin b1.req1 = r; b1.data1 = d; end else begin b1.req0 = r; b1.data0 = d; end
    end else begin
      if (id) begin b0.req1 = r; b0.data1 = d; end else begin b0.req0 = r; b0.data0 = d; end
    end
  endtask

  function automatic logic get_ack(input bit inst, input bit id);
    if (inst) return id ? b1.ack1 : b1.ack0;
    return id ? b0.ack1 : b0.ack0;
  endfunction

  // One single-requester word on instance inst, checked end to end.
  task automatic word(input bit inst, input bit id, input logic [7:0] d,
                      input int exp_cnt, input string tag);
    logic [7:0] tr;
    set_req(inst, id, 1'b1, d);
    tick();
    check({tag, "_ack"}, get_ack(inst, id), 1);
    check({tag, "_ack_other"}, get_ack(inst, ~id), 0);
    set_req(inst, id, 1'b0, d);
    if (inst) begin
      check({tag, "_clr"}, b1.det_reset_n, 0);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      tr[k] = inst ? b1.det_in : b0.det_in;
      tick();
    end
    check({tag, "_valid"}, inst ? b1.res_valid : b0.res_valid, 1);
    check({tag, "_id"}, inst ? b1.res_id : b0.res_id, id);
    check({tag, "_count"}, inst ? b1.res_count : b0.res_count, exp_cnt);
    check({tag, "_hit"}, inst ? b1.res_hit : b0.res_hit, exp_cnt != 0);
    check({tag, "_trace"}, tr, d);
    tick();
    check({tag, "_idle"}, inst ? b1.busy : b0.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last_c;
    b1.req0 = 0; b1.req1 = 0; b1.data0 = '0; b1.data1 = '0;
    b0.req0 = 0; b0.req1 = 0; b0.data0 = '0; b0.data1 = '0;

    tick(); tick();
    check("rst_busy", b1.busy, 0);
    check("rst_valid", b1.res_valid, 0);
    check("rst_ack", {b1.ack0, b1.ack1}, 0);
    check("rst_det_in", b1.det_in, 0);
    check("rst_detrst1", b1.det_reset_n, 0);
    check("rst_detrst0", b0.det_reset_n, 0);
    check("rst_count", b1.res_count, 0);
    reset = 1'b0;
    #1 check("post_rst_detrst", b1.det_reset_n, 1);

    word(1'b1, 1'b0, 8'h44, 2, "single");
    word(1'b1, 1'b1, 8'h00, 0, "zeros");
    word(1'b1, 1'b0, 8'hFF, 0, "ones");
    check("hold_count", b1.res_count, 0);

    // Reset during SHIFT cycle 3 drops the word.
    set_req(1'b1, 1'b1, 1'b1, 8'hAA);
    tick();
    set_req(1'b1, 1'b1, 1'b0, 8'hAA);
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    #1 check("mid_rst_detrst", b1.det_reset_n, 0);
    tick();
    check("mid_rst_busy", b1.busy, 0);
    check("mid_rst_valid", b1.res_valid, 0);
    check("mid_rst_det_in", b1.det_in, 0);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (b1.res_valid) n++;
      tick();
    end
    check("mid_rst_no_result", n, 0);
    word(1'b1, 1'b1, 8'h44, 2, "after_rst");

    // Round robin with both requests held; pointer freshly reset.
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    b1.data0 = 8'h44; b1.data1 = 8'h40; b1.req0 = 1; b1.req1 = 1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(b1.ack0 || b1.ack1) && n < 20) begin tick(); n++; end
      check($sformatf("arb%0d_ack0", g), b1.ack0, (g % 2) == 0);
      check($sformatf("arb%0d_ack1", g), b1.ack1, (g % 2) == 1);
      tick();
      check($sformatf("arb%0d_ackw", g), b1.ack0 | b1.ack1, 0);
      n = 0;
      while (!b1.res_valid && n < 20) begin tick(); n++; end
      check($sformatf("arb%0d_valid", g), b1.res_valid, 1);
      check($sformatf("arb%0d_id", g), b1.res_id, g % 2);
      check($sformatf("arb%0d_count", g), b1.res_count, (g % 2) ? 1 : 2);
      if (g == 3) begin b1.req0 = 0; b1.req1 = 0; end
    end
    tick(); tick();

    // Back-to-back words from requester 1: one grant every W+3 cycles.
    b1.data1 = 8'h44; b1.req1 = 1;
    last_c = 0;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (!b1.ack1 && n < 20) begin tick(); n++; end
      check($sformatf("b2b%0d_ack", g), b1.ack1, 1);
      if (g > 0) check($sformatf("b2b%0d_gap", g), cyc - last_c, 11);
      last_c = cyc;
      tick();
      check($sformatf("b2b%0d_ackw", g), b1.ack1, 0);
      n = 0;
      while (!b1.res_valid && n < 20) begin tick(); n++; end
      check($sformatf("b2b%0d_count", g), b1.res_count, 2);
      if (g == 2) b1.req1 = 0;
    end
    tick(); tick();

    // Carry-over: ...,1,0 then 0 completes 0100 only if history survives.
    reset = 1'b1; tick(); reset = 1'b0;
    word(1'b0, 1'b0, 8'h40, 1, "carry0_a");
    word(1'b0, 1'b0, 8'h00, 1, "carry0_b");
    word(1'b1, 1'b0, 8'h40, 1, "carry1_a");
    word(1'b1, 1'b0, 8'h00, 0, "carry1_b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_scan_sched.md
# pattern_scan_sched

Scheduler that shares one serial pattern detector (patterns 0100 / 00010, rightmost bit first) between two word-level requesters. It arbitrates round-robin between requesters, optionally clears the detector, and shifts the granted W-bit word into the detector LSB first. It counts detector matches during the shift and returns a per-word match count tagged with the requester id. It sits between the word-parallel producers and the bit-serial detector.

## Interface
- W, 8: data word width, ≥2.
- CLEAR_EN, 1: 1 = clear the detector for one cycle before each word; 0 = detector state carries across words.
- CW, $clog2(W+1): width of res_count.

- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- req0, req1  in  1  word request, requester 0 / 1.
- data0, data1  in  W  word for requester 0 / 1; bit 0 is sent first.
- ack0, ack1  out  1  one-cycle pulse: word accepted.
- det_in  out  1  serial bit to detector.
- det_reset_n  out  1  active-low clear to detector.
- det_z  in  1  detector match flag. Valid at the rising edge that ends the cycle in which a bit was driven.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  one-cycle result pulse.
- res_id  out  1  requester served.
- res_count  out  CW  matches counted for the word.
- res_hit  out  1  res_count != 0.

## Operation
- States: IDLE, CLEAR, SHIFT, DONE.
- **IDLE**
  - Requests are sampled only here.
  - If any req is high at an edge: grant, latch the granted data into a shift register, clear the match counter and bit index, and record the id.
  - The ack for the granted requester is high for exactly the following cycle.
  - Next state is CLEAR if CLEAR_EN, else SHIFT.
- **Arbitration**
  - Single request: grant it.
  - Both requests: grant the requester not served last. The pointer updates on each grant.
  - After reset, requester 0 wins the first tie.
- **CLEAR** (one cycle): det_reset_n = 0, det_in = 0; next state is SHIFT.
- **SHIFT** (exactly W cycles)
  - det_in = shift register bit 0.
  - At each edge: if det_z, the counter increments. Then the register shifts right and the index increments.
  - After the W-th edge, next state is DONE.
  - The counter never exceeds W; no saturation logic is needed.
- **DONE** (one cycle)
  - res_valid = 1. res_id, res_count and res_hit are stable and registered.
  - Next state is IDLE.
  - res_id, res_count and res_hit hold their values until the next DONE.
- **det_reset_n**
  - 0 in CLEAR and while reset is high.
  - 1 otherwise, including IDLE.
  - With CLEAR_EN = 0, matches whose last bit lies in the current word are counted even if they started in the previous word.
- **Requester rules**
  - A requester must deassert req or change data in the cycle after its ack.
  - A req held high is treated as a new word at the next IDLE.
  - data is sampled only at the grant edge.
- **Reset (any state, including mid-SHIFT)**
  - Next state is IDLE; the in-flight word is dropped with no res_valid.
  - All outputs are 0 except det_reset_n = 0 while reset is high.
  - The round-robin pointer returns to its reset value.
- Requests are ignored while reset is high.

## Timing
- Grant edge is E0. With CLEAR_EN = 1:
  - ack and CLEAR occupy [E0, E1).
  - SHIFT occupies [E1, E1+W).
  - res_valid occupies [E1+W, E2+W).
  - The earliest next grant is at edge E3+W.
- With CLEAR_EN = 0, every step is one cycle earlier.
- Throughput: one word per W+3 cycles (W+2 with CLEAR_EN = 0).
- det_z sampled at edge E(k+2) reflects bits 0..k (CLEAR_EN = 1). The detector is assumed to update mid-cycle on the falling edge.
- There is no combinational path from any input to any output; all outputs are registered or decoded from state.

## Test plan
- **Single word:** req0 with data0 = 8'h44, CLEAR_EN = 1 → ack0 one cycle after the grant edge; res_valid 9 cycles after the grant edge with res_id = 0, res_count = 2, res_hit = 1.
- **No-match words:** data 8'h00 and 8'hFF → res_count = 0, res_hit = 0; det_in serial trace equals the data LSB first.
- **Arbitration:** req0 and req1 held high continuously with different data → grants alternate 0, 1, 0, 1; the first grant after reset goes to 0; each result's res_id matches its data.
- **Reset mid-operation:** reset asserted at SHIFT cycle 3 → next cycle shows IDLE, busy = 0, no res_valid, det_reset_n = 0 during reset; a subsequent request completes normally.
- **Carry-over:** with CLEAR_EN = 0, word 8'h40 followed by word 8'h00 (bit stream ...,1,0 then 0,0,...) → the count reflects matches completing in the second word; with CLEAR_EN = 1 the second result is 0.
- **Back-to-back from one requester:** req1 held high → a new grant every W+3 cycles; ack1 pulses are one cycle wide; res_count never exceeds W.
